// File: rtl/lagrange_basis_eval.sv
// lagrange_basis_eval: Horner evaluation of the Lagrange basis over 0..npoints-1 at tau; define LAGRANGE_BASIS_EVAL_DOT_EN to add the y dot-product result
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_PRIME
`define F_PRIME 61'h1FFFFFFFFFFFFFFF
`endif
module lagrange_basis_eval #(
  parameter int npoints = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [`F_NBITS-1:0]               tau,
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
  input  logic [npoints-1:0][`F_NBITS-1:0]  y,
`endif
  output logic [npoints-1:0][`F_NBITS-1:0]  basis,
  output logic [`F_NBITS-1:0]               result,
  output logic                              busy,
  output logic                              ready
);
  localparam int W = `F_NBITS;
  localparam int CW = $clog2(npoints);
  localparam logic [W-1:0] P = W'(`F_PRIME);
  if (npoints < 2 || npoints > 16) begin : g_bad_npoints
    $error("lagrange_basis_eval: npoints must be in 2..16");
  end
  function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, P}) ? W'(s - {1'b0, P}) : W'(s);
  endfunction
  function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(t % {{W{1'b0}}, P});
  endfunction
  function automatic logic [W-1:0] f_pow(input logic [W-1:0] b, input logic [W-1:0] e);
    logic [W-1:0] r;
    r = W'(1);
    for (int n = W - 1; n >= 0; n--) begin
      r = f_mul(r, r);
      if (e[n]) r = f_mul(r, b);
    end
    return r;
  endfunction
  // Expand prod_{j!=i}(x-j) term by term, then scale by the inverse denominator (Fermat).
  function automatic logic [npoints*npoints*W-1:0] f_coeffs();
    logic [npoints*npoints*W-1:0] r;
    logic [W-1:0] poly [npoints];
    logic [W-1:0] d, nj;
    r = '0;
    for (int i = 0; i < npoints; i++) begin
      for (int k = 0; k < npoints; k++) poly[k] = '0;
      poly[0] = W'(1);
      d = W'(1);
      for (int j = 0; j < npoints; j++) begin
        if (j != i) begin
          nj = (j == 0) ? '0 : P - W'(j);
          for (int k = npoints - 1; k > 0; k--) poly[k] = f_add(poly[k-1], f_mul(nj, poly[k]));
          poly[0] = f_mul(nj, poly[0]);
          d = f_mul(d, (i > j) ? W'(i - j) : P - W'(j - i));
        end
      end
      d = f_pow(d, P - W'(2));
      for (int k = 0; k < npoints; k++) r[(i*npoints+k)*W +: W] = f_mul(poly[k], d);
    end
    return r;
  endfunction
  localparam logic [npoints*npoints*W-1:0] C = f_coeffs();
  typedef enum logic [1:0] {S_IDLE, S_HORNER, S_DOT, S_DONE} state_t;
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
  localparam state_t S_END = S_DOT;
  logic [npoints-1:0][W-1:0] r_y;
  logic [W-1:0]              r_result;
`else
  localparam state_t S_END = S_DONE;
`endif
  state_t                    r_state, w_next;
  logic [W-1:0]              r_tau, r_acc, w_c, w_lead, w_step;
  logic [CW-1:0]             r_i, r_k;
  logic [npoints-1:0][W-1:0] r_basis;
  logic                      w_last_i;
  always_comb begin
    w_last_i = r_i == CW'(npoints - 1);
    w_c = C[(int'(r_i) * npoints + int'(r_k)) * W +: W];
    w_lead = C[((w_last_i ? 0 : int'(r_i) + 1) * npoints + npoints - 1) * W +: W];
    w_step = f_add(f_mul(r_acc, r_tau), w_c);
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = (r_state == S_IDLE)   ? (en ? S_HORNER : S_IDLE) :
             (r_state == S_HORNER) ? ((r_k == '0 && w_last_i) ? S_END : S_HORNER) :
             (r_state == S_DOT)    ? (w_last_i ? S_DONE : S_DOT) : S_IDLE;
  end
  always_comb begin
    busy = r_state != S_IDLE;
    ready = r_state == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tau <= '0;
      r_acc <= '0;
      r_i <= '0;
      r_k <= '0;
      r_basis <= '0;
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
      r_y <= '0;
      r_result <= '0;
`endif
    end else if (r_state == S_IDLE && en) begin
      r_tau <= tau;
      r_acc <= C[(npoints-1)*W +: W];
      r_i <= '0;
      r_k <= CW'(npoints - 2);
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
      r_y <= y;
`endif
    end else if (r_state == S_HORNER) begin
      r_acc <= w_step;
      r_k <= r_k - 1'b1;
      if (r_k == '0) begin
        r_basis[r_i] <= w_step;
        r_i <= w_last_i ? '0 : r_i + 1'b1;
        r_acc <= w_lead;
        r_k <= CW'(npoints - 2);
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
        r_result <= '0;
`endif
      end
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
    end else if (r_state == S_DOT) begin
      r_result <= f_add(r_result, f_mul(r_y[r_i], r_basis[r_i]));
      r_i <= w_last_i ? '0 : r_i + 1'b1;
`endif
    end
  end
  assign basis = r_basis;
`ifdef LAGRANGE_BASIS_EVAL_DOT_EN
  assign result = r_result;
`else
  assign result = '0;
`endif
endmodule
